// File: rtl/asap_pkg.sv
// Shared definitions for the asap scheduler and related multi-client blocks.
package asap_pkg;

  // Scheduler FSM encoding
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_RESP   = 3'd3,
    S_DRAIN  = 3'd4
  } state_e;

  // Ceiling log2, used to size requester indices and the round-robin pointer
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above ptr_i, with wrap.
module rr_arbiter
  import asap_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned PtrW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PtrW-1:0] idx_o,
  output logic            valid_o
);

  // One spare bit so ptr + offset can exceed NREQ before the wrap
  logic [PtrW:0] cand;

  // Scan candidates ptr, ptr+1, ... (mod NREQ) and keep the first asserted one
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_i} + (PtrW + 1)'(k);
      if (cand >= (PtrW + 1)'(NREQ)) begin
        cand = cand - (PtrW + 1)'(NREQ);
      end
      if (!valid_o && req_i[cand[PtrW-1:0]]) begin
        valid_o                = 1'b1;
        idx_o                  = cand[PtrW-1:0];
        gnt_o[cand[PtrW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/asap_sched.sv
// Round-robin scheduler sharing one asap datapath among NREQ requesters.
module asap_sched
  import asap_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CYCW  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*WIDTH-1:0] req_in0_i,
  input  logic [NREQ*WIDTH-1:0] req_in1_i,
  output logic [NREQ-1:0]       req_ack_o,
  output logic [NREQ-1:0]       rsp_valid_o,
  input  logic [NREQ-1:0]       rsp_ready_i,
  output logic [WIDTH-1:0]      rsp_data_o,
  output logic [CYCW-1:0]       rsp_cyc_o,
  output logic                  busy_o,
  output logic                  asap_go_o,
  output logic [WIDTH-1:0]      asap_in0_o,
  output logic [WIDTH-1:0]      asap_in1_o,
  input  logic [WIDTH-1:0]      asap_out_i,
  input  logic                  asap_done_i
);

  localparam int unsigned PtrW = clog2(NREQ);

  state_e          state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] own_q, own_d;
  logic [WIDTH-1:0] in0_q, in0_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CYCW-1:0]  cnt_q, cnt_d;
  logic [CYCW-1:0]  cyc_q, cyc_d;

  logic [NREQ-1:0] gnt;
  logic [PtrW-1:0] gnt_idx;
  logic            gnt_valid;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req_i  (req_valid_i),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .valid_o(gnt_valid)
  );

  // Next-state, operand/result capture and decoded handshake outputs
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    own_d       = own_q;
    in0_d       = in0_q;
    in1_d       = in1_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    req_ack_o   = '0;
    rsp_valid_o = '0;
    asap_go_o   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Arbitration only happens here, so requests raised mid-operation wait
        if (gnt_valid) begin
          req_ack_o = gnt;
          in0_d     = req_in0_i[gnt_idx*WIDTH +: WIDTH];
          in1_d     = req_in1_i[gnt_idx*WIDTH +: WIDTH];
          own_d     = gnt_idx;
          ptr_d     = (gnt_idx == PtrW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        asap_go_o = 1'b1;
        cnt_d     = CYCW'(1);
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (asap_done_i) begin
          data_d  = asap_out_i;
          cyc_d   = cnt_q;
          state_d = S_RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid_o[own_q] = 1'b1;
        if (rsp_ready_i[own_q]) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // A done still high from the last op must not complete the next one
        if (!asap_done_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      in0_q   <= '0;
      in1_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      in0_q   <= in0_d;
      in1_q   <= in1_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign asap_in0_o = in0_q;
  assign asap_in1_o = in1_q;
  assign rsp_data_o = data_q;
  assign rsp_cyc_o  = cyc_q;

endmodule
